golden: RTL and testbench
=========================

GOLDEN -- requirements
Module: golden

Interface
REQ-001 Parameter ADDR_WIDTH, default 10: width of instruction and data word addresses.
REQ-002 Parameter SIZE, default 32: data/instruction/register width.
REQ-003 CLK  input  1: single clock; all state updates on rising edge.
REQ-004 RESET  input  1: synchronous, active-high reset.
REQ-005 idata  input  SIZE: instruction word at iaddr, from combinational ROM.
REQ-006 iaddr  output  ADDR_WIDTH: instruction word address = PC[ADDR_WIDTH+1:2].
REQ-007 daddr  output  ADDR_WIDTH: data word address = ALU result[ADDR_WIDTH+1:2].
REQ-008 ddata_r  input  SIZE: data word read combinationally from RAM at daddr.
REQ-009 ddata_w  output  SIZE: store data (rs2 value).
REQ-010 d_rw  output  1: 1 = RAM write at next rising CLK, 0 = read.
REQ-011 reg_write_data  output  SIZE: value presented to register-file write port this cycle (writeback mux output).

Function
REQ-012 Single-cycle RV32I core: each instruction fetched, decoded, executed and retired in one CLK cycle; PC, register file and RAM update on the same edge.
REQ-013 PC is 32-bit byte address; next PC = PC+4 unless a taken branch/jump.
REQ-014 Register file: 32 x SIZE, two combinational read ports, one write port; x0 reads 0 always, writes to x0 discarded.
REQ-015 R-type (opcode 0110011): ADD, SUB, SLL, SLT, SLTU, XOR, SRL, SRA, OR, AND; shifts use rs2[4:0].
REQ-016 I-type ALU (0010011): ADDI, SLTI, SLTIU, XORI, ORI, ANDI, SLLI, SRLI, SRAI; immediates sign-extended from 12 bits.
REQ-017 LW (0000011): rd <= ddata_r, address rs1+imm; SW (0100011): d_rw=1, ddata_w=rs2, address rs1+S-imm.
REQ-018 Branches (1100011): BEQ, BNE, BLT, BGE, BLTU, BGEU; taken -> PC <= PC + B-imm (sign-extended, bit0=0).
REQ-019 JAL: rd <= PC+4, PC <= PC+J-imm; JALR: rd <= PC+4, PC <= (rs1+imm) & ~1.
REQ-020 LUI: rd <= {imm[31:12],12'b0}; AUIPC: rd <= PC + {imm[31:12],12'b0}.
REQ-021 Arithmetic modulo 2^SIZE; overflow ignored; SLT/BLT signed, SLTU/BLTU unsigned.
REQ-022 d_rw=1 only during SW; 0 for all other instructions.
REQ-023 Unsupported opcode: treated as NOP (no register write, d_rw=0, PC+4).
REQ-024 reg_write_data for instructions without register write: ALU result (don't-care to the register file).
REQ-025 No alignment checks; low two address bits ignored for iaddr and daddr; addresses wrap modulo 2^ADDR_WIDTH words.

Reset
REQ-026 Rising CLK with RESET=1: PC <= 0, all 32 registers <= 0.
REQ-027 While RESET=1: d_rw forced 0, no register write; iaddr reflects PC (0 after first reset edge).
REQ-028 RESET asserted mid-program: takes effect at the next rising edge, discarding the instruction in flight.
REQ-029 After RESET deasserted, first instruction executed is the one at iaddr 0.

Verification
REQ-030 RESET=1 one cycle, then ADDI x1,x0,5 -> reg_write_data=5, next cycle iaddr=1, x1=5.
REQ-031 ADDI x1,x0,-1; SLTU x2,x0,x1; SLT x3,x0,x1 -> x2=1, x3=0.
REQ-032 ADDI x1,x0,42; SW x1,8(x0); LW x2,8(x0) -> SW cycle: d_rw=1, daddr=2, ddata_w=42; LW reg_write_data=42.
REQ-033 ADDI x1,x0,1; BNE x1,x0,+8 at byte 4 -> next iaddr=3; BEQ x1,x0,+8 -> next iaddr=PC/4+1.
REQ-034 JAL x1,+12 at byte 8 -> x1=12, iaddr=5; ADDI x0,x0,7 -> x0 reads 0.
REQ-035 Fibonacci program from ROM (loop with ADD/ADDI/SW/BNE) for 500 cycles -> reg_write_data sequence 0,1,1,2,3,5,8,... and RAM holds matching stored terms.

Source files
------------

// File: rtl/golden.sv
// golden: single-cycle RV32I core.
//
// Every instruction is fetched, decoded, executed and retired in one CLK cycle. The PC, the
// register file and the external data RAM all update on the same rising edge. Instruction and
// data memories are external and read combinationally.
//
// Parameters
//   ADDR_WIDTH  word-address width of the instruction and data memories
//   SIZE        data / instruction / register width (32 for RV32I)
//
// Ports
//   CLK             clock, all state updates on the rising edge
//   RESET           synchronous active-high reset (PC and all registers to 0)
//   idata           instruction word at iaddr
//   iaddr           instruction word address, PC[ADDR_WIDTH+1:2]
//   daddr           data word address, ALU result[ADDR_WIDTH+1:2]
//   ddata_r         data word read from RAM at daddr
//   ddata_w         store data (rs2 value)
//   d_rw            1 = RAM write at the next rising edge (SW only), 0 = read
//   reg_write_data  writeback mux output presented to the register-file write port
module golden #(
    parameter int unsigned ADDR_WIDTH = 10,
    parameter int unsigned SIZE       = 32
) (
    input  logic                  CLK,
    input  logic                  RESET,
    input  logic [SIZE-1:0]       idata,
    output logic [ADDR_WIDTH-1:0] iaddr,
    output logic [ADDR_WIDTH-1:0] daddr,
    input  logic [SIZE-1:0]       ddata_r,
    output logic [SIZE-1:0]       ddata_w,
    output logic                  d_rw,
    output logic [SIZE-1:0]       reg_write_data
);

    // Major opcodes handled by this core; anything else retires as a NOP.
    localparam logic [6:0] OpLui    = 7'b0110111;
    localparam logic [6:0] OpAuipc  = 7'b0010111;
    localparam logic [6:0] OpJal    = 7'b1101111;
    localparam logic [6:0] OpJalr   = 7'b1100111;
    localparam logic [6:0] OpBranch = 7'b1100011;
    localparam logic [6:0] OpLoad   = 7'b0000011;
    localparam logic [6:0] OpStore  = 7'b0100011;
    localparam logic [6:0] OpImm    = 7'b0010011;
    localparam logic [6:0] OpReg    = 7'b0110011;

    // ------------------------------------------------------------------
    // Architectural state
    // ------------------------------------------------------------------
    logic [31:0]     pc_q;
    logic [31:0]     pc_d;
    logic [SIZE-1:0] regs_q [32];

    // ------------------------------------------------------------------
    // Instruction fields
    // ------------------------------------------------------------------
    logic [31:0] instr;
    logic [6:0]  opcode;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [2:0]  funct3;
    logic        alt;       // instr[30]: selects SUB / SRA / SRAI

    assign instr  = idata[31:0];
    assign opcode = instr[6:0];
    assign rd     = instr[11:7];
    assign funct3 = instr[14:12];
    assign rs1    = instr[19:15];
    assign rs2    = instr[24:20];
    assign alt    = instr[30];

    logic is_lui;
    logic is_auipc;
    logic is_jal;
    logic is_jalr;
    logic is_branch;
    logic is_load;
    logic is_store;
    logic is_imm;
    logic is_reg;

    assign is_lui    = (opcode == OpLui);
    assign is_auipc  = (opcode == OpAuipc);
    assign is_jal    = (opcode == OpJal);
    assign is_jalr   = (opcode == OpJalr);
    assign is_branch = (opcode == OpBranch);
    assign is_load   = (opcode == OpLoad);
    assign is_store  = (opcode == OpStore);
    assign is_imm    = (opcode == OpImm);
    assign is_reg    = (opcode == OpReg);

    // ------------------------------------------------------------------
    // Immediates (32-bit, sign-extended from the instruction)
    // ------------------------------------------------------------------
    logic [31:0] imm_i;
    logic [31:0] imm_s;
    logic [31:0] imm_b;
    logic [31:0] imm_u;
    logic [31:0] imm_j;

    assign imm_i = {{20{instr[31]}}, instr[31:20]};
    assign imm_s = {{20{instr[31]}}, instr[31:25], instr[11:7]};
    assign imm_b = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
    assign imm_u = {instr[31:12], 12'b0};
    assign imm_j = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};

    // ------------------------------------------------------------------
    // Register file read ports; x0 is hard-wired to zero on read
    // ------------------------------------------------------------------
    logic [SIZE-1:0] rs1_val;
    logic [SIZE-1:0] rs2_val;

    assign rs1_val = (rs1 == 5'd0) ? '0 : regs_q[rs1];
    assign rs2_val = (rs2 == 5'd0) ? '0 : regs_q[rs2];

    // ------------------------------------------------------------------
    // ALU operand selection
    // ------------------------------------------------------------------
    // LUI and AUIPC reuse the adder: LUI adds the U-immediate to zero, AUIPC to the PC.
    // Branches feed rs2 so the comparators below see rs1 vs rs2.
    logic [31:0]     imm_sel;
    logic [SIZE-1:0] op_a;
    logic [SIZE-1:0] op_b;
    logic [4:0]      shamt;

    always_comb begin
        imm_sel = imm_i;
        if (is_store) begin
            imm_sel = imm_s;
        end else if (is_lui || is_auipc) begin
            imm_sel = imm_u;
        end
    end

    always_comb begin
        op_a = rs1_val;
        if (is_auipc) begin
            op_a = SIZE'(pc_q);
        end else if (is_lui) begin
            op_a = '0;
        end
        op_b = (is_reg || is_branch) ? rs2_val : SIZE'($signed(imm_sel));
    end

    assign shamt = op_b[4:0];

    // ------------------------------------------------------------------
    // Comparators shared by SLT(U)/SLTI(U) and the branch unit
    // ------------------------------------------------------------------
    logic eq;
    logic lt_signed;
    logic lt_unsigned;

    assign eq          = (op_a == op_b);
    assign lt_signed   = ($signed(op_a) < $signed(op_b));
    assign lt_unsigned = (op_a < op_b);

    // ------------------------------------------------------------------
    // ALU: funct3 decode only for OP / OP-IMM, plain add for everything else
    // ------------------------------------------------------------------
    logic [SIZE-1:0] alu_res;

    always_comb begin
        alu_res = op_a + op_b;
        if (is_reg || is_imm) begin
            case (funct3)
                3'b000:  alu_res = (is_reg && alt) ? (op_a - op_b) : (op_a + op_b);
                3'b001:  alu_res = op_a << shamt;
                3'b010:  alu_res = SIZE'(lt_signed);
                3'b011:  alu_res = SIZE'(lt_unsigned);
                3'b100:  alu_res = op_a ^ op_b;
                3'b101:  alu_res = alt ? ($signed(op_a) >>> shamt) : (op_a >> shamt);
                3'b110:  alu_res = op_a | op_b;
                default: alu_res = op_a & op_b;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Branch condition; reserved funct3 values never branch
    // ------------------------------------------------------------------
    logic br_cond;

    always_comb begin
        case (funct3)
            3'b000:  br_cond = eq;
            3'b001:  br_cond = !eq;
            3'b100:  br_cond = lt_signed;
            3'b101:  br_cond = !lt_signed;
            3'b110:  br_cond = lt_unsigned;
            3'b111:  br_cond = !lt_unsigned;
            default: br_cond = 1'b0;
        endcase
    end

    // ------------------------------------------------------------------
    // Next PC
    // ------------------------------------------------------------------
    logic [31:0] pc_plus4;

    assign pc_plus4 = pc_q + 32'd4;

    always_comb begin
        pc_d = pc_plus4;
        if (is_jal) begin
            pc_d = pc_q + imm_j;
        end else if (is_jalr) begin
            pc_d = 32'(alu_res) & ~32'd1;
        end else if (is_branch && br_cond) begin
            pc_d = pc_q + imm_b;
        end
    end

    // ------------------------------------------------------------------
    // Writeback
    // ------------------------------------------------------------------
    logic writes_rd;
    logic reg_we;

    assign writes_rd = is_reg || is_imm || is_load || is_jal || is_jalr || is_lui || is_auipc;
    assign reg_we    = writes_rd && (rd != 5'd0);

    always_comb begin
        reg_write_data = alu_res;
        if (is_load) begin
            reg_write_data = ddata_r;
        end else if (is_jal || is_jalr) begin
            reg_write_data = SIZE'(pc_plus4);
        end
    end

    // ------------------------------------------------------------------
    // Memory interface
    // ------------------------------------------------------------------
    assign iaddr   = pc_q[ADDR_WIDTH+1:2];
    assign daddr   = alu_res[ADDR_WIDTH+1:2];
    assign ddata_w = rs2_val;
    // Reset suppresses the store of the instruction in flight.
    assign d_rw    = is_store && !RESET;

    // ------------------------------------------------------------------
    // State update
    // ------------------------------------------------------------------
    always_ff @(posedge CLK) begin
        if (RESET) begin
            pc_q <= '0;
            for (int i = 0; i < 32; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            pc_q <= pc_d;
            if (reg_we) begin
                regs_q[rd] <= reg_write_data;
            end
        end
    end

endmodule

// File: tb/tb_golden.sv
// Bench for golden: directed programs plus a randomly generated ROM, executed in lockstep with
// an instruction-level reference interpreter holding its own PC, registers and RAM image.
module tb_golden;

    localparam int unsigned AW    = 10;
    localparam int unsigned DW    = 32;
    localparam int unsigned Words = 1 << AW;

    logic          CLK = 1'b0;
    logic          RESET;
    logic [DW-1:0] idata;
    logic [AW-1:0] iaddr;
    logic [AW-1:0] daddr;
    logic [DW-1:0] ddata_r;
    logic [DW-1:0] ddata_w;
    logic          d_rw;
    logic [DW-1:0] reg_write_data;

    logic [31:0] rom   [Words];
    logic [31:0] ram   [Words];
    logic [31:0] m_ram [Words];
    logic [31:0] m_x   [32];
    logic [31:0] m_pc;
    bit          m_valid;
    int unsigned n_vec;
    int unsigned n_err;

    golden #(
        .ADDR_WIDTH(AW),
        .SIZE      (DW)
    ) dut (
        .CLK           (CLK),
        .RESET         (RESET),
        .idata         (idata),
        .iaddr         (iaddr),
        .daddr         (daddr),
        .ddata_r       (ddata_r),
        .ddata_w       (ddata_w),
        .d_rw          (d_rw),
        .reg_write_data(reg_write_data)
    );

    always #5 CLK = ~CLK;

    assign idata   = rom[iaddr];
    assign ddata_r = ram[daddr];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    // ---------------- instruction encoders ----------------
    function automatic logic [31:0] enc_r(input int f7, input int rs2, input int rs1,
                                          input int f3, input int rd);
        return {7'(f7), 5'(rs2), 5'(rs1), 3'(f3), 5'(rd), 7'h33};
    endfunction

    function automatic logic [31:0] enc_i(input int imm, input int rs1, input int f3,
                                          input int rd, input int opc);
        return {12'(imm), 5'(rs1), 3'(f3), 5'(rd), 7'(opc)};
    endfunction

    function automatic logic [31:0] enc_s(input int imm, input int rs2, input int rs1);
        logic [11:0] im;
        im = 12'(imm);
        return {im[11:5], 5'(rs2), 5'(rs1), 3'd2, im[4:0], 7'h23};
    endfunction

    function automatic logic [31:0] enc_b(input int imm, input int rs2, input int rs1,
                                          input int f3);
        logic [12:0] im;
        im = 13'(imm);
        return {im[12], im[10:5], 5'(rs2), 5'(rs1), 3'(f3), im[4:1], im[11], 7'h63};
    endfunction

    function automatic logic [31:0] enc_j(input int imm, input int rd);
        logic [20:0] im;
        im = 21'(imm);
        return {im[20], im[10:1], im[11], im[19:12], 5'(rd), 7'h6f};
    endfunction

    function automatic int pick_reg();
        return ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 31))
                                           : int'($urandom_range(0, 7));
    endfunction

    function automatic logic [31:0] rand_ins();
        int rd;
        int rs1;
        int rs2;
        int f3;
        int imm;
        rd  = pick_reg();
        rs1 = pick_reg();
        rs2 = pick_reg();
        f3  = int'($urandom_range(0, 7));
        imm = int'($urandom_range(0, 4095)) - 2048;
        case ($urandom_range(0, 12))
            0, 1, 2: return enc_r(((f3 == 0 || f3 == 5) && $urandom_range(0, 1) == 1) ? 32 : 0,
                                  rs2, rs1, f3, rd);
            3, 4, 5: begin
                if (f3 == 1) imm = imm & 31;
                else if (f3 == 5) imm = (imm & 31) | (($urandom_range(0, 1) == 1) ? 1024 : 0);
                return enc_i(imm, rs1, f3, rd, 'h13);
            end
            6:  return enc_i(imm, rs1, 2, rd, 'h03);
            7:  return enc_s(imm, rs2, rs1);
            8:  return enc_b((int'($urandom_range(0, 64)) - 32) * 4, rs2, rs1,
                             (f3 == 2 || f3 == 3) ? f3 + 2 : f3);
            9:  return enc_j((int'($urandom_range(0, 128)) - 64) * 4, rd);
            10: return enc_i(imm, rs1, 0, rd, 'h67);
            11: return {20'($urandom()), 5'(rd), ($urandom_range(0, 1) == 1) ? 7'h37 : 7'h17};
            default: begin
                case ($urandom_range(0, 3))
                    0:       return {25'($urandom()), 7'h0f};
                    1:       return {25'($urandom()), 7'h73};
                    2:       return {25'($urandom()), 7'h7f};
                    default: return 32'h0;
                endcase
            end
        endcase
    endfunction

    // ---------------- reference model ----------------
    function automatic logic [31:0] alu_ref(input int f3, input bit sub, input bit sra,
                                            input logic [31:0] x, input logic [31:0] y);
        case (f3)
            0:       return sub ? x - y : x + y;
            1:       return x << y[4:0];
            2:       return ($signed(x) < $signed(y)) ? 32'd1 : 32'd0;
            3:       return (x < y) ? 32'd1 : 32'd0;
            4:       return x ^ y;
            5:       return sra ? $signed(x) >>> y[4:0] : x >> y[4:0];
            6:       return x | y;
            default: return x & y;
        endcase
    endfunction

    function automatic bit taken_ref(input int f3, input logic [31:0] x, input logic [31:0] y);
        case (f3)
            0:       return x == y;
            1:       return x != y;
            4:       return $signed(x) < $signed(y);
            5:       return $signed(x) >= $signed(y);
            6:       return x < y;
            7:       return x >= y;
            default: return 1'b0;
        endcase
    endfunction

    // One clock cycle: compare the DUT against the model, advance the model, let the RAM take
    // any store on the rising edge, and return on the following falling edge.
    task automatic step();
        logic [31:0] ins, a, b, wd, npc, addr;
        logic [31:0] ii, is, ib, iu, ij;
        bit          we, st;
        int          rd, f3;
        bit          wr_en;
        logic [AW-1:0] wr_a;
        logic [31:0] wr_d;
        #1;
        wr_en = d_rw;
        wr_a  = daddr;
        wr_d  = ddata_w;
        if (RESET) begin
            if (m_valid) check("rst_iaddr", 32'(iaddr), 32'(m_pc[AW+1:2]));
            check("rst_d_rw", 32'(d_rw), 32'd0);
            m_pc = 32'd0;
            for (int i = 0; i < 32; i++) m_x[i] = 32'd0;
            m_valid = 1'b1;
        end else if (m_valid) begin
            ins = rom[m_pc[AW+1:2]];
            rd  = int'(ins[11:7]);
            f3  = int'(ins[14:12]);
            a   = m_x[ins[19:15]];
            b   = m_x[ins[24:20]];
            ii  = {{20{ins[31]}}, ins[31:20]};
            is  = {{20{ins[31]}}, ins[31:25], ins[11:7]};
            ib  = {{20{ins[31]}}, ins[7], ins[30:25], ins[11:8], 1'b0};
            iu  = {ins[31:12], 12'b0};
            ij  = {{12{ins[31]}}, ins[19:12], ins[20], ins[30:21], 1'b0};
            we  = 1'b0;
            st  = 1'b0;
            wd  = 32'd0;
            addr = 32'd0;
            npc = m_pc + 32'd4;
            case (ins[6:0])
                7'h37: begin we = 1'b1; wd = iu; end
                7'h17: begin we = 1'b1; wd = m_pc + iu; end
                7'h6f: begin we = 1'b1; wd = m_pc + 32'd4; npc = m_pc + ij; end
                7'h67: begin we = 1'b1; wd = m_pc + 32'd4; npc = (a + ii) & ~32'd1; end
                7'h63: if (taken_ref(f3, a, b)) npc = m_pc + ib;
                7'h03: begin we = 1'b1; addr = a + ii; wd = m_ram[addr[AW+1:2]]; end
                7'h23: begin st = 1'b1; addr = a + is; end
                7'h13: begin we = 1'b1; wd = alu_ref(f3, 1'b0, ins[30], a, ii); end
                7'h33: begin we = 1'b1; wd = alu_ref(f3, ins[30], ins[30], a, b); end
                default: ;
            endcase
            check("iaddr", 32'(iaddr), 32'(m_pc[AW+1:2]));
            check("d_rw", 32'(d_rw), 32'(st));
            if (st) begin
                check("daddr", 32'(daddr), 32'(addr[AW+1:2]));
                check("ddata_w", ddata_w, b);
                m_ram[addr[AW+1:2]] = b;
            end
            if (we) check("wdata", reg_write_data, wd);
            if (we && rd != 0) m_x[rd] = wd;
            m_pc = npc;
        end
        @(posedge CLK);
        if (wr_en) ram[wr_a] = wr_d;
        @(negedge CLK);
    endtask

    task automatic clear_mem();
        for (int i = 0; i < Words; i++) begin
            rom[i]   = 32'h0;
            ram[i]   = 32'h0;
            m_ram[i] = 32'h0;
        end
    endtask

    task automatic apply_reset();
        RESET = 1'b1;
        step();
        RESET = 1'b0;
    endtask

    logic [31:0] fib [42];
    int unsigned k;
    int unsigned diffs;

    initial begin
        n_vec   = 0;
        n_err   = 0;
        m_valid = 1'b0;
        m_pc    = 32'd0;
        RESET   = 1'b1;
        clear_mem();
        @(negedge CLK);

        // ADDI x1,x0,5 right after a one-cycle reset.
        rom[0] = enc_i(5, 0, 0, 1, 'h13);
        rom[1] = enc_s(0, 1, 0);
        apply_reset();
        #1 check("t1_wdata", reg_write_data, 32'd5);
        step();
        #1 check("t1_iaddr", 32'(iaddr), 32'd1);
        check("t1_x1", ddata_w, 32'd5);
        step();

        // Signed vs unsigned compare of -1.
        clear_mem();
        rom[0] = enc_i(-1, 0, 0, 1, 'h13);
        rom[1] = enc_r(0, 1, 0, 3, 2);
        rom[2] = enc_r(0, 1, 0, 2, 3);
        rom[3] = enc_s(0, 2, 0);
        rom[4] = enc_s(4, 3, 0);
        apply_reset();
        step();
        #1 check("t2_sltu", reg_write_data, 32'd1);
        step();
        #1 check("t2_slt", reg_write_data, 32'd0);
        step();
        #1 check("t2_x2", ddata_w, 32'd1);
        step();
        #1 check("t2_x3", ddata_w, 32'd0);
        step();

        // Store then load back.
        clear_mem();
        rom[0] = enc_i(42, 0, 0, 1, 'h13);
        rom[1] = enc_s(8, 1, 0);
        rom[2] = enc_i(8, 0, 2, 2, 'h03);
        apply_reset();
        step();
        #1 check("t3_sw_rw", 32'(d_rw), 32'd1);
        check("t3_sw_addr", 32'(daddr), 32'd2);
        check("t3_sw_data", ddata_w, 32'd42);
        step();
        #1 check("t3_lw", reg_write_data, 32'd42);
        step();

        // Taken BNE, then not-taken BEQ.
        clear_mem();
        rom[0] = enc_i(1, 0, 0, 1, 'h13);
        rom[1] = enc_b(8, 0, 1, 1);
        rom[3] = enc_b(8, 0, 1, 0);
        apply_reset();
        step();
        step();
        #1 check("t4_bne", 32'(iaddr), 32'd3);
        step();
        #1 check("t4_beq", 32'(iaddr), 32'd4);
        step();

        // JAL link value and x0 immutability.
        clear_mem();
        rom[0] = enc_i(0, 0, 0, 0, 'h13);
        rom[1] = enc_i(0, 0, 0, 0, 'h13);
        rom[2] = enc_j(12, 1);
        rom[5] = enc_i(7, 0, 0, 0, 'h13);
        rom[6] = enc_s(4, 0, 0);
        rom[7] = enc_s(0, 1, 0);
        apply_reset();
        step();
        step();
        #1 check("t5_link", reg_write_data, 32'd12);
        step();
        #1 check("t5_iaddr", 32'(iaddr), 32'd5);
        check("t5_x0_wd", reg_write_data, 32'd7);
        step();
        #1 check("t5_x0", ddata_w, 32'd0);
        step();
        #1 check("t5_x1", ddata_w, 32'd12);
        step();

        // Fibonacci loop: 40 terms stored to RAM words 0..39.
        clear_mem();
        fib[0] = 32'd0;
        fib[1] = 32'd1;
        for (int i = 2; i < 42; i++) fib[i] = fib[i-1] + fib[i-2];
        rom[0]  = enc_i(0, 0, 0, 1, 'h13);
        rom[1]  = enc_i(1, 0, 0, 2, 'h13);
        rom[2]  = enc_i(0, 0, 0, 4, 'h13);
        rom[3]  = enc_i(40, 0, 0, 5, 'h13);
        rom[4]  = enc_s(0, 1, 4);
        rom[5]  = enc_r(0, 2, 1, 0, 3);
        rom[6]  = enc_i(0, 2, 0, 1, 'h13);
        rom[7]  = enc_i(0, 3, 0, 2, 'h13);
        rom[8]  = enc_i(4, 4, 0, 4, 'h13);
        rom[9]  = enc_i(-1, 5, 0, 5, 'h13);
        rom[10] = enc_b(-24, 0, 5, 1);
        rom[11] = enc_j(0, 0);
        apply_reset();
        k = 0;
        for (int c = 0; c < 500; c++) begin
            #1;
            if (m_pc == 32'd16 && k < 40) begin
                check("fib_sw", ddata_w, fib[k]);
                check("fib_daddr", 32'(daddr), k);
            end
            if (m_pc == 32'd20 && k < 40) begin
                check("fib_add", reg_write_data, fib[k+2]);
                k++;
            end
            step();
        end
        check("fib_terms", k, 32'd40);
        for (int i = 0; i < 40; i++) check("fib_ram", ram[i], fib[i]);

        // Random ROM, random RAM image, occasional mid-program resets.
        for (int i = 0; i < Words; i++) begin
            rom[i]   = rand_ins();
            ram[i]   = $urandom();
            m_ram[i] = ram[i];
        end
        RESET = 1'b1;
        step();
        step();
        RESET = 1'b0;
        for (int c = 0; c < 4000; c++) begin
            RESET = ($urandom_range(0, 299) == 0);
            step();
        end
        RESET = 1'b0;
        diffs = 0;
        for (int i = 0; i < Words; i++) if (ram[i] !== m_ram[i]) diffs++;
        check("rand_ram", diffs, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
